regfile_wb_arbiter: RTL and testbench

//   Shares the register file's single write port among NUM_REQ writeback requesters (e.g. ALU, load unit).

---
 rtl/riscv_rf_pkg.sv | 11 +
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 24 ++
 rtl/regfile_wb_arbiter.sv | 75 +++++++
 tb/tb_regfile_wb_arbiter.sv | 138 +++++++++++++
 5 files changed

// File: rtl/riscv_rf_pkg.sv
// riscv_rf_pkg: register-file widths and the writeback request record shared by the arbiter slice
package riscv_rf_pkg;
    localparam int XLEN = 64;
    localparam int NUM_REGS = 32;
    localparam int REG_AW = $clog2(NUM_REGS);
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: requester handshake, register-file write port and decode bypass signals
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int XLEN = riscv_rf_pkg::XLEN,
    parameter int REG_AW = riscv_rf_pkg::REG_AW
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*REG_AW-1:0] req_rd;
    logic [NUM_REQ*XLEN-1:0]   req_data;
    logic [REG_AW-1:0]         rf_rd;
    logic [XLEN-1:0]           rf_write_data;
    logic                      rf_reg_write;
    logic [ID_W-1:0]           grant_id;
    logic [REG_AW-1:0]         byp_rs1;
    logic [REG_AW-1:0]         byp_rs2;
    logic                      byp_hit1;
    logic                      byp_hit2;
    logic [XLEN-1:0]           byp_data1;
    logic [XLEN-1:0]           byp_data2;
    modport master (
        output req_valid, req_rd, req_data, byp_rs1, byp_rs2,
        input  req_ready, rf_rd, rf_write_data, rf_reg_write, grant_id,
        input  byp_hit1, byp_hit2, byp_data1, byp_data2
    );
    modport slave (
        input  req_valid, req_rd, req_data, byp_rs1, byp_rs2,
        output req_ready, rf_rd, rf_write_data, rf_reg_write, grant_id,
        output byp_hit1, byp_hit2, byp_data1, byp_data2
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester at or above ptr, wrapping, one-hot and encoded
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       any_req
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [ID_W-1:0] cand;
    // Walk offsets from farthest to nearest so the nearest valid index is the last one kept
    always_comb begin
        grant_id = '0;
        cand = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ID_W'((int'(ptr) + i) % NUM_REQ);
            grant_id = req[cand] ? cand : grant_id;
        end
        any_req = |req;
        grant = any_req ? (NUM_REQ'(1) << grant_id) : '0;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter feeding the register-file write port
// Define RF_WB_BYPASS_EN to forward the staged write to the decode read ports.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN = riscv_rf_pkg::XLEN,
    parameter int REG_AW = riscv_rf_pkg::REG_AW
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
);
    import riscv_rf_pkg::*;
    localparam int ID_W = $clog2(NUM_REQ);
    logic [ID_W-1:0]    ptr_q, ptr_d, id_q, id_d, win_id;
    logic [NUM_REQ-1:0] grant;
    logic               any_req, valid_q, valid_d;
    wb_req_t            win, stage_q, stage_d;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (bus.req_valid),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_id (win_id),
        .any_req  (any_req)
    );
    // x0 requests are accepted but leave the stage contents untouched
    always_comb begin
        win.rd = bus.req_rd[int'(win_id)*REG_AW +: REG_AW];
        win.data = bus.req_data[int'(win_id)*XLEN +: XLEN];
        valid_d = any_req && win.rd != REG_ZERO;
        ptr_d = !any_req ? ptr_q : (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        stage_d = valid_d ? win : stage_q;
        id_d = valid_d ? win_id : id_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            valid_q <= 1'b0;
            stage_q <= '0;
            id_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            valid_q <= valid_d;
            stage_q <= stage_d;
            id_q <= id_d;
        end
    end
    // Reset masks the handshake and the pending write in the same cycle it is asserted
    always_comb begin
        bus.req_ready = rst_n ? grant : '0;
        bus.rf_reg_write = valid_q & rst_n;
        bus.rf_rd = stage_q.rd;
        bus.rf_write_data = stage_q.data;
        bus.grant_id = id_q;
    end
`ifdef RF_WB_BYPASS_EN
    logic hit1, hit2;
    always_comb begin
        hit1 = bus.rf_reg_write && stage_q.rd != REG_ZERO && stage_q.rd == bus.byp_rs1;
        hit2 = bus.rf_reg_write && stage_q.rd != REG_ZERO && stage_q.rd == bus.byp_rs2;
        bus.byp_hit1 = hit1;
        bus.byp_hit2 = hit2;
        bus.byp_data1 = hit1 ? stage_q.data : '0;
        bus.byp_data2 = hit2 ? stage_q.data : '0;
    end
`else
    logic unused_byp;
    assign unused_byp = ^{bus.byp_rs1, bus.byp_rs2};
    always_comb begin
        bus.byp_hit1 = 1'b0;
        bus.byp_hit2 = 1'b0;
        bus.byp_data1 = '0;
        bus.byp_data2 = '0;
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: vector table plus write scoreboard for the two-requester writeback arbiter
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    regfile_wb_arbiter_if #(.NUM_REQ(2)) bus ();
    regfile_wb_arbiter #(.NUM_REQ(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    typedef struct {
        logic        rst_n;
        logic [1:0]  valid;
        logic [4:0]  rd0;
        logic [63:0] d0;
        logic [4:0]  rd1;
        logic [63:0] d1;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  exp_ready;
    } vec_t;
    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        id;
    } exp_t;
    vec_t vt [22];
    exp_t q [$];
    exp_t last;
    logic [63:0] rf_m [32] = '{default: 64'd0};
    int n_vec = 0;
    int n_err = 0;
    always @(posedge clk) if (bus.rf_reg_write && bus.rf_rd != 5'd0) rf_m[bus.rf_rd] <= bus.rf_write_data;
    function automatic vec_t mk(input int r, input int v, input int a0, input logic [63:0] x0,
                                input int a1, input logic [63:0] x1, input int s1, input int s2, input int er);
        vec_t t;
        t.rst_n = 1'(r);
        t.valid = 2'(v);
        t.rd0 = 5'(a0);
        t.d0 = x0;
        t.rd1 = 5'(a1);
        t.d1 = x1;
        t.rs1 = 5'(s1);
        t.rs2 = 5'(s2);
        t.exp_ready = 2'(er);
        return t;
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        logic we, h1, h2;
        logic [4:0] r;
        bus.req_valid = v.valid;
        bus.req_rd = {v.rd1, v.rd0};
        bus.req_data = {v.d1, v.d0};
        bus.byp_rs1 = v.rs1;
        bus.byp_rs2 = v.rs2;
        rst_n = v.rst_n;
        @(negedge clk);
        if (q.size() != 0) begin
            e = q.pop_front();
            we = e.we & v.rst_n;
`ifdef RF_WB_BYPASS_EN
            h1 = we && e.rd == v.rs1;
            h2 = we && e.rd == v.rs2;
`else
            h1 = 1'b0;
            h2 = 1'b0;
`endif
            chk($sformatf("v%0d rf_reg_write", idx), 64'(bus.rf_reg_write), 64'(we));
            chk($sformatf("v%0d rf_rd", idx), 64'(bus.rf_rd), 64'(e.rd));
            chk($sformatf("v%0d rf_write_data", idx), bus.rf_write_data, e.data);
            chk($sformatf("v%0d grant_id", idx), 64'(bus.grant_id), 64'(e.id));
            chk($sformatf("v%0d byp_hit1", idx), 64'(bus.byp_hit1), 64'(h1));
            chk($sformatf("v%0d byp_hit2", idx), 64'(bus.byp_hit2), 64'(h2));
            chk($sformatf("v%0d byp_data1", idx), bus.byp_data1, h1 ? e.data : 64'd0);
            chk($sformatf("v%0d byp_data2", idx), bus.byp_data2, h2 ? e.data : 64'd0);
        end
        chk($sformatf("v%0d req_ready", idx), 64'(bus.req_ready), 64'(v.exp_ready));
        if (!v.rst_n) begin
            last = '{1'b0, 5'd0, 64'd0, 1'b0};
        end else if (v.exp_ready != 2'b00) begin
            r = v.exp_ready[1] ? v.rd1 : v.rd0;
            last.we = r != 5'd0;
            if (last.we) begin
                last.rd = r;
                last.data = v.exp_ready[1] ? v.d1 : v.d0;
                last.id = v.exp_ready[1];
            end
        end else begin
            last.we = 1'b0;
        end
        q.push_back(last);
        @(posedge clk);
        #1;
    endtask
    initial begin
        vt[0]  = mk(0, 3, 1, 64'hA0, 2, 64'hB0, 0, 0, 0);
        vt[1]  = mk(0, 3, 1, 64'hA0, 2, 64'hB0, 0, 0, 0);
        vt[2]  = mk(1, 3, 1, 64'hA1, 2, 64'hB1, 0, 0, 1);
        vt[3]  = mk(1, 3, 1, 64'hA2, 2, 64'hB1, 1, 2, 2);
        vt[4]  = mk(1, 3, 1, 64'hA2, 2, 64'hB3, 2, 1, 1);
        vt[5]  = mk(1, 3, 1, 64'hA5, 2, 64'hB3, 1, 2, 2);
        vt[6]  = mk(1, 1, 1, 64'hA5, 0, 64'h0, 2, 0, 1);
        vt[7]  = mk(1, 1, 5, 64'hDEAD, 0, 64'h0, 2, 1, 1);
        vt[8]  = mk(1, 0, 0, 64'h0, 0, 64'h0, 5, 5, 0);
        vt[9]  = mk(1, 2, 0, 64'h0, 0, 64'hFF, 0, 0, 2);
        vt[10] = mk(1, 3, 9, 64'hC9, 10, 64'hCA, 5, 0, 1);
        vt[11] = mk(1, 3, 9, 64'hD9, 10, 64'hCA, 9, 10, 2);
        vt[12] = mk(1, 1, 9, 64'hD9, 0, 64'h0, 10, 9, 1);
        vt[13] = mk(1, 1, 11, 64'hE1, 0, 64'h0, 9, 9, 1);
        vt[14] = mk(1, 1, 7, 64'h1234, 0, 64'h0, 11, 0, 1);
        vt[15] = mk(1, 0, 0, 64'h0, 0, 64'h0, 7, 8, 0);
        vt[16] = mk(1, 1, 3, 64'h3333, 0, 64'h0, 7, 0, 1);
        vt[17] = mk(0, 0, 0, 64'h0, 0, 64'h0, 3, 3, 0);
        vt[18] = mk(1, 3, 4, 64'hF4, 6, 64'hF6, 0, 0, 1);
        vt[19] = mk(1, 2, 0, 64'h0, 6, 64'hF6, 4, 6, 2);
        vt[20] = mk(1, 0, 0, 64'h0, 0, 64'h0, 6, 0, 0);
        vt[21] = mk(1, 0, 0, 64'h0, 0, 64'h0, 6, 6, 0);
        last = '{1'b0, 5'd0, 64'd0, 1'b0};
        q.push_back(last);
        for (int i = 0; i < 22; i++) apply(vt[i], i);
        chk("x1", rf_m[1], 64'hA5);
        chk("x2", rf_m[2], 64'hB3);
        chk("x3 after reset", rf_m[3], 64'h0);
        chk("x5", rf_m[5], 64'hDEAD);
        chk("x6", rf_m[6], 64'hF6);
        chk("x7", rf_m[7], 64'h1234);
        chk("x9", rf_m[9], 64'hD9);
        chk("x10", rf_m[10], 64'hCA);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
